regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with two write ports, NREAD bypassed read ports and a
// per-register pending-write scoreboard (issue adds an entry, write-with-clear retires one).
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREAD  = 3,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [4:0]                waddr0,
    input  logic [4:0]                waddr1,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic                      wclr0,
    input  logic                      wclr1,
    input  logic [5*NREAD-1:0]        raddr,
    output logic [DATA_W*NREAD-1:0]   rdata,
    output logic [NREAD-1:0]          busy,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_addr,
    output logic                      issue_ready,
    output logic                      sb_err
);

    localparam int unsigned NREG = 32;
    localparam int unsigned EW   = (CNT_W > 2) ? CNT_W : 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic [CNT_W-1:0]  cnt_ar [NREG];
    logic [1:0]        ret    [NREG];
    logic [NREG-1:0]   under;
    logic              sb_err_q;
    logic              sb_err_d;
    logic              issue_acc;
    logic [4:0]        ra     [NREAD];

    // Retirements per register and the count left after them, floored at zero
    always_comb begin
        under = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            ret[r] = {1'b0, we0 & wclr0 & (waddr0 == 5'(r))}
                   + {1'b0, we1 & wclr1 & (waddr1 == 5'(r))};
            if (r != 0 && EW'(ret[r]) > EW'(cnt_q[r])) begin
                under[r] = 1'b1;
            end
            if (r == 0 || EW'(ret[r]) > EW'(cnt_q[r])) begin
                cnt_ar[r] = '0;
            end else begin
                cnt_ar[r] = CNT_W'(EW'(cnt_q[r]) - EW'(ret[r]));
            end
        end
    end

    assign issue_ready = (issue_addr == 5'd0) || (cnt_ar[issue_addr] != CNT_MAX);
    assign issue_acc   = issue_valid & issue_ready & (issue_addr != 5'd0);

    always_comb begin
        for (int r = 0; r < int'(NREG); r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_ar[r] + CNT_W'(issue_acc && (issue_addr == 5'(r)));
        end
        // Port 1 is applied last so it wins on an address collision
        if (we0 && waddr0 != 5'd0) regs_d[waddr0] = wdata0;
        if (we1 && waddr1 != 5'd0) regs_d[waddr1] = wdata1;
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        sb_err_d  = sb_err_q | (|under);
    end

    // Read ports: write bypass first, busy reflects this cycle's retirements only
    always_comb begin
        rdata = '0;
        busy  = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            ra[i] = raddr[5*i +: 5];
            if (we1 && waddr1 == ra[i] && ra[i] != 5'd0) begin
                rdata[DATA_W*i +: DATA_W] = wdata1;
            end else if (we0 && waddr0 == ra[i] && ra[i] != 5'd0) begin
                rdata[DATA_W*i +: DATA_W] = wdata0;
            end else begin
                rdata[DATA_W*i +: DATA_W] = regs_q[ra[i]];
            end
            busy[i] = (cnt_ar[ra[i]] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations are queued as stimulus is
// driven and popped/compared once the combinational outputs have settled.
module tb_regfile_scoreboard;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREAD  = 3;
    localparam int unsigned CNT_W  = 2;

    localparam int W_RDATA = 0;
    localparam int W_BUSY  = 1;
    localparam int W_READY = 2;
    localparam int W_ERR   = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    we0, we1, wclr0, wclr1;
    logic [4:0]              waddr0, waddr1;
    logic [DATA_W-1:0]       wdata0, wdata1;
    logic [5*NREAD-1:0]      raddr;
    logic [DATA_W*NREAD-1:0] rdata;
    logic [NREAD-1:0]        busy;
    logic                    issue_valid;
    logic [4:0]              issue_addr;
    logic                    issue_ready;
    logic                    sb_err;

    typedef struct {
        string             tag;
        int                what;
        int                port;
        logic [DATA_W-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_scoreboard #(.DATA_W(DATA_W), .NREAD(NREAD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1), .wclr0(wclr0), .wclr1(wclr1),
        .raddr(raddr), .rdata(rdata), .busy(busy),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_ready(issue_ready), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] observe(input int what, input int port);
        case (what)
            W_RDATA: observe = rdata[DATA_W*port +: DATA_W];
            W_BUSY:  observe = DATA_W'(busy[port]);
            W_READY: observe = DATA_W'(issue_ready);
            default: observe = DATA_W'(sb_err);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int what, input int port,
                              input logic [DATA_W-1:0] e);
        exp_t x;
        x.tag = tag; x.what = what; x.port = port; x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        #1;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check_eq(x.tag, observe(x.what, x.port), x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; wclr0 = 0; wclr1 = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr = '0; issue_valid = 0; issue_addr = '0;
    endtask

    task automatic set_ra(input int port, input logic [4:0] a);
        raddr[5*port +: 5] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle();
        tick();
        // Under reset: bypass visible, stored data 0, ready 1, no state update
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEAD_0005; wclr0 = 1;
        set_ra(0, 5'd5); set_ra(1, 5'd7);
        issue_valid = 1; issue_addr = 5'd3;
        expect_val("rst_bypass", W_RDATA, 0, 32'hDEAD_0005);
        expect_val("rst_rd_r7",  W_RDATA, 1, 32'h0);
        expect_val("rst_busy",   W_BUSY,  0, 32'h0);
        expect_val("rst_ready",  W_READY, 0, 32'h1);
        expect_val("rst_err",    W_ERR,   0, 32'h0);
        drain();
        tick();
        idle(); set_ra(0, 5'd5); set_ra(1, 5'd3);
        expect_val("rst_no_store", W_RDATA, 0, 32'h0);
        expect_val("rst_no_issue", W_BUSY,  1, 32'h0);
        expect_val("rst_no_err",   W_ERR,   0, 32'h0);
        drain();
        rst = 1'b1;
        tick();

        // Same-cycle bypass and store of r5 through port 0
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'h1234_5678; set_ra(0, 5'd5);
        expect_val("r5_bypass", W_RDATA, 0, 32'h1234_5678);
        drain(); tick();
        idle(); set_ra(0, 5'd5);
        expect_val("r5_stored", W_RDATA, 0, 32'h1234_5678);
        drain();

        // Write collision on r7: port 1 wins
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'hAAAA_0000;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h0000_BBBB; set_ra(1, 5'd7);
        expect_val("r7_bypass_prio", W_RDATA, 1, 32'h0000_BBBB);
        drain(); tick();
        idle(); set_ra(1, 5'd7);
        expect_val("r7_stored_prio", W_RDATA, 1, 32'h0000_BBBB);
        drain();
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF; set_ra(2, 5'd0);
        expect_val("r0_bypass", W_RDATA, 2, 32'h0);
        expect_val("r0_busy",   W_BUSY,  2, 32'h0);
        drain(); tick();
        idle(); set_ra(2, 5'd0);
        expect_val("r0_stored", W_RDATA, 2, 32'h0);
        drain();

        // Fill r3 to CNT_MAX, retire one, refill
        for (int k = 0; k < 3; k++) begin
            idle(); issue_valid = 1; issue_addr = 5'd3;
            expect_val($sformatf("r3_issue%0d_ready", k), W_READY, 0, 32'h1);
            drain(); tick();
        end
        idle(); set_ra(0, 5'd3); issue_addr = 5'd3;
        expect_val("r3_full_busy",  W_BUSY,  0, 32'h1);
        expect_val("r3_full_ready", W_READY, 0, 32'h0);
        drain();
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h33; wclr0 = 1;
        expect_val("r3_retire_ready", W_READY, 0, 32'h1);
        expect_val("r3_retire_busy",  W_BUSY,  0, 32'h1);
        expect_val("r3_retire_data",  W_RDATA, 0, 32'h33);
        drain(); tick();
        idle(); issue_valid = 1; issue_addr = 5'd3;
        expect_val("r3_cnt2_ready", W_READY, 0, 32'h1);
        drain(); tick();
        idle(); issue_addr = 5'd3;
        expect_val("r3_refull_ready", W_READY, 0, 32'h0);
        drain(); tick();

        // r4: retire the last entry with same-cycle read, then issue+retire
        idle(); issue_valid = 1; issue_addr = 5'd4;
        drain(); tick();
        idle(); set_ra(1, 5'd4);
        expect_val("r4_cnt1_busy", W_BUSY, 1, 32'h1);
        drain();
        we1 = 1; waddr1 = 5'd4; wdata1 = 32'h55; wclr1 = 1;
        expect_val("r4_last_busy", W_BUSY,  1, 32'h0);
        expect_val("r4_last_data", W_RDATA, 1, 32'h55);
        drain(); tick();
        for (int k = 0; k < 2; k++) begin
            idle(); issue_valid = 1; issue_addr = 5'd4;
            drain(); tick();
        end
        idle(); set_ra(0, 5'd4); issue_valid = 1; issue_addr = 5'd4;
        we0 = 1; waddr0 = 5'd4; wdata0 = 32'h66; wclr0 = 1;
        expect_val("r4_issret_ready", W_READY, 0, 32'h1);
        expect_val("r4_issret_busy",  W_BUSY,  0, 32'h1);
        drain(); tick();
        idle(); set_ra(0, 5'd4);
        we0 = 1; waddr0 = 5'd4; wdata0 = 32'h77; wclr0 = 1;
        we1 = 1; waddr1 = 5'd4; wdata1 = 32'h88; wclr1 = 1;
        expect_val("r4_cnt2_drain_busy", W_BUSY,  0, 32'h0);
        expect_val("r4_drain_data",      W_RDATA, 0, 32'h88);
        drain(); tick();
        idle(); set_ra(0, 5'd4);
        expect_val("r4_no_underflow", W_ERR,  0, 32'h0);
        expect_val("r4_idle_busy",    W_BUSY, 0, 32'h0);
        drain();

        // Retire with zero count on r9 sets the sticky error
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h99; wclr0 = 1;
        expect_val("r9_err_not_yet", W_ERR, 0, 32'h0);
        drain(); tick();
        idle(); set_ra(2, 5'd9);
        expect_val("r9_err_set", W_ERR,   0, 32'h1);
        expect_val("r9_data",    W_RDATA, 2, 32'h99);
        drain(); tick();
        expect_val("r9_err_sticky", W_ERR, 0, 32'h1);
        drain();

        // Mid-cycle asynchronous reset with r3 still full
        idle(); set_ra(0, 5'd3); set_ra(1, 5'd5); issue_addr = 5'd3;
        expect_val("pre_rst_busy", W_BUSY, 0, 32'h1);
        drain();
        @(posedge clk);
        #2 rst = 1'b0;
        expect_val("arst_busy",  W_BUSY,  0, 32'h0);
        expect_val("arst_ready", W_READY, 0, 32'h1);
        expect_val("arst_err",   W_ERR,   0, 32'h0);
        expect_val("arst_r5",    W_RDATA, 1, 32'h0);
        drain();
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_val("post_rst_busy",  W_BUSY,  0, 32'h0);
        expect_val("post_rst_ready", W_READY, 0, 32'h1);
        expect_val("post_rst_err",   W_ERR,   0, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
